// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported unified memory between the instruction
//            fetch port (read-only) and the MEM-stage load/store port. The
//            data port has fixed priority; an optional guard stops fetch from
//            starving. Each hold-until-ack request becomes exactly one
//            memory transaction over a ready-based backend handshake.
// Options  : MEMARB_STARVE_GUARD_EN - when defined, a 4-bit counter forces a
//            fetch grant after STARVE_LIMIT consecutive data grants made
//            while fetch was waiting.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            if_req/if_addr       - fetch request and address (in)
//            if_rdata/if_ack      - fetch read data and completion pulse (out)
//            d_req/d_we/d_addr/d_wdata - data request, direction, addr, wdata
//            d_rdata/d_ack        - load data and completion pulse (out)
//            m_req/m_we/m_addr/m_wdata - memory transaction (out, registered)
//            m_rdata/m_ready      - memory read data and completion (in)
//            busy                 - high whenever a grant is outstanding
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready,
  output logic          busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  localparam logic [3:0] c_LIMIT = 4'(STARVE_LIMIT);

  logic [1:0]    r_state;
  logic          r_owner_d;   // 1: data port owns the grant, 0: fetch
  logic          r_m_req;
  logic          r_m_we;
  logic [AW-1:0] r_m_addr;
  logic [DW-1:0] r_m_wdata;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          r_if_ack;
  logic          r_d_ack;
  logic          r_busy;

  logic          w_starve_hit;
  logic          w_grant_d;
  logic          w_grant_f;

`ifdef MEMARB_STARVE_GUARD_EN
  logic [3:0]    r_starve;

  // Fetch has waited through the tolerated number of data grants.
  assign w_starve_hit = if_req && d_req && (r_starve == c_LIMIT);

  // Only data grants taken while fetch waits count toward starvation; the
  // counter cannot pass the limit because at the limit fetch wins instead.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= 4'd0;
    end else if (r_state == S_IDLE) begin
      if (w_grant_d) begin
        r_starve <= if_req ? (r_starve + 4'd1) : 4'd0;
      end else if (w_grant_f) begin
        r_starve <= 4'd0;
      end
    end
  end
`else
  logic          w_unused_cfg;

  assign w_starve_hit = 1'b0;
  assign w_unused_cfg = ^c_LIMIT;
`endif

  // Arbitration on the request lines sampled in IDLE.
  assign w_grant_d = d_req && !w_starve_hit;
  assign w_grant_f = if_req && !w_grant_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_owner_d  <= 1'b0;
      r_m_req    <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_if_ack   <= 1'b0;
      r_d_ack    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      // Acks are single-cycle pulses; they are only set on BUSY->ACK.
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            r_m_req   <= 1'b1;
            r_m_we    <= d_we;
            r_m_addr  <= d_addr;
            r_m_wdata <= d_wdata;
            r_owner_d <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_BUSY;
          end else if (w_grant_f) begin
            r_m_req   <= 1'b1;
            r_m_we    <= 1'b0;
            r_m_addr  <= if_addr;
            r_owner_d <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Transaction fields stay frozen until the memory completes.
          if (m_ready) begin
            r_m_req <= 1'b0;
            r_state <= S_ACK;
            if (r_owner_d) begin
              r_d_ack <= 1'b1;
              if (!r_m_we) begin
                r_d_rdata <= m_rdata;
              end
            end else begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= m_rdata;
            end
          end
        end
        S_ACK: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_m_req <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign m_req    = r_m_req;
  assign m_we     = r_m_we;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;
  assign if_rdata = r_if_rdata;
  assign d_rdata  = r_d_rdata;
  assign if_ack   = r_if_ack;
  assign d_ack    = r_d_ack;
  assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. A transaction-level
//            reference (one grant in flight, owner, completion, ack) predicts
//            every output each cycle; directed steps cover the reference
//            scenarios, then randomized requesters and memory latency run.
//            Honours MEMARB_STARVE_GUARD_EN the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_ack;
  logic        m_req;
  logic        m_we;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;
  logic        m_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(16), .DW(16), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy)
  );

  // Reference: at most one grant in flight, then one ack cycle.
  bit          mf_flight, mf_owner_d, mf_we, mf_ack_if, mf_ack_d;
  logic [15:0] mf_addr, mf_wdata, mf_if_rd, mf_d_rd;
  int          mf_starve;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the reference by one clock using the inputs just sampled.
  function automatic void model_step();
    bit guard_hit;
    bit data_wins;
    if (reset) begin
      mf_flight = 0; mf_ack_if = 0; mf_ack_d = 0; mf_we = 0;
      mf_addr = '0; mf_wdata = '0; mf_if_rd = '0; mf_d_rd = '0; mf_starve = 0;
      return;
    end
    if (mf_ack_if || mf_ack_d) begin
      mf_ack_if = 0;
      mf_ack_d  = 0;
    end else if (mf_flight) begin
      if (m_ready) begin
        mf_flight = 0;
        if (mf_owner_d) begin
          mf_ack_d = 1;
          if (!mf_we) mf_d_rd = m_rdata;
        end else begin
          mf_ack_if = 1;
          mf_if_rd  = m_rdata;
        end
      end
    end else if (if_req || d_req) begin
      guard_hit = 0;
`ifdef MEMARB_STARVE_GUARD_EN
      guard_hit = if_req && d_req && (mf_starve == LIMIT);
`endif
      data_wins = d_req && !guard_hit;
      mf_flight = 1;
      if (data_wins) begin
        mf_starve  = if_req ? mf_starve + 1 : 0;
        mf_owner_d = 1;
        mf_we      = d_we;
        mf_addr    = d_addr;
        mf_wdata   = d_wdata;
      end else begin
        mf_starve  = 0;
        mf_owner_d = 0;
        mf_we      = 0;
        mf_addr    = if_addr;
      end
    end
  endfunction

  task automatic check_outputs();
    chk("m_req", m_req, mf_flight);
    if (mf_flight) begin
      chk("m_addr", m_addr, mf_addr);
      chk("m_we", m_we, mf_we);
      if (mf_owner_d) chk("m_wdata", m_wdata, mf_wdata);
    end
    chk("if_ack", if_ack, mf_ack_if);
    chk("d_ack", d_ack, mf_ack_d);
    chk("if_rdata", if_rdata, mf_if_rd);
    chk("d_rdata", d_rdata, mf_d_rd);
    chk("busy", busy, mf_flight || mf_ack_if || mf_ack_d);
    chk("ack_exclusive", if_ack && d_ack, 1'b0);
  endtask

  // Current inputs are cycle n; after this, outputs show cycle n+1.
  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check_outputs();
  endtask

  int          bc;
  int          gcount;
  logic [9:0]  gvec;
  bit          prev_mreq;
  int          waitc;
  int          ack_seen;

  initial begin
    reset = 1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; m_rdata = '0; m_ready = 0;
    mf_flight = 0; mf_owner_d = 0; mf_we = 0; mf_ack_if = 0; mf_ack_d = 0;
    mf_addr = '0; mf_wdata = '0; mf_if_rd = '0; mf_d_rd = '0; mf_starve = 0;

    // Reset state
    @(negedge clk);
    tick(); tick();
    chk("rst_m_req", m_req, 1'b0);
    chk("rst_m_addr", m_addr, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_if_rdata", if_rdata, 16'h0000);
    reset = 0;

    // Single fetch
    if_req = 1; if_addr = 16'h0010;
    tick();
    chk("fetch_m_req", m_req, 1'b1);
    chk("fetch_m_addr", m_addr, 16'h0010);
    chk("fetch_m_we", m_we, 1'b0);
    tick();
    m_ready = 1; m_rdata = 16'hA5C3;
    tick();
    chk("fetch_ack", if_ack, 1'b1);
    chk("fetch_rdata", if_rdata, 16'hA5C3);
    if_req = 0; m_ready = 0;
    tick();
    chk("fetch_idle_busy", busy, 1'b0);

    // Simultaneous requests: data write wins, fetch follows
    if_req = 1; if_addr = 16'h0040;
    d_req = 1; d_we = 1; d_addr = 16'h0200; d_wdata = 16'h1234;
    tick();
    chk("sim_m_we", m_we, 1'b1);
    chk("sim_m_addr", m_addr, 16'h0200);
    chk("sim_m_wdata", m_wdata, 16'h1234);
    m_ready = 1; m_rdata = 16'h5555;
    tick();
    chk("sim_d_ack", d_ack, 1'b1);
    chk("sim_d_rdata_kept", d_rdata, 16'h0000);
    d_req = 0; m_ready = 0;
    tick();
    tick();
    chk("sim_fetch_m_req", m_req, 1'b1);
    chk("sim_fetch_m_addr", m_addr, 16'h0040);
    m_ready = 1; m_rdata = 16'h0F0F;
    tick();
    chk("sim_fetch_ack", if_ack, 1'b1);
    if_req = 0; m_ready = 0;
    tick();

    // Memory wait states: ready arrives five cycles after grant
    d_req = 1; d_we = 0; d_addr = 16'h0300;
    tick();
    bc = 0;
    for (int i = 1; i <= 4; i++) begin
      if (busy) bc++;
      chk("wait_m_addr", m_addr, 16'h0300);
      chk("wait_m_req", m_req, 1'b1);
      tick();
    end
    if (busy) bc++;
    m_ready = 1; m_rdata = 16'hBEEF;
    tick();
    if (busy) bc++;
    chk("wait_d_ack", d_ack, 1'b1);
    chk("wait_d_rdata", d_rdata, 16'hBEEF);
    d_req = 0; m_ready = 0;
    tick();
    chk("wait_busy_cycles", bc, 6);

    // Starvation: both requests held continuously
    reset = 1;
    tick();
    reset = 0;
    if_req = 1; if_addr = 16'h1000; d_req = 1; d_we = 1; d_addr = 16'h2000;
    gcount = 0; gvec = '0; prev_mreq = 0;
    for (int i = 0; i < 80 && gcount < 10; i++) begin
      if (d_ack) begin d_addr = d_addr + 16'd1; d_wdata = 16'($urandom); end
      if (if_ack) if_addr = if_addr + 16'd1;
      m_ready = m_req;
      m_rdata = 16'($urandom);
      tick();
      if (m_req && !prev_mreq) begin
        gvec[gcount] = m_we;
        gcount++;
      end
      prev_mreq = m_req;
    end
    chk("starve_grant_count", gcount, 10);
`ifdef MEMARB_STARVE_GUARD_EN
    chk("starve_grant_order", gvec, 10'b0111101111);
`else
    chk("starve_grant_order", gvec, 10'b1111111111);
`endif

    // Reset mid-transaction
    if_req = 0; d_req = 0; m_ready = 0;
    reset = 1;
    tick();
    reset = 0;
    if_req = 1; if_addr = 16'h0777;
    tick();
    tick();
    chk("rmid_busy_before", busy, 1'b1);
    ack_seen = 0;
    reset = 1;
    tick();
    if (if_ack || d_ack) ack_seen++;
    chk("rmid_m_req", m_req, 1'b0);
    chk("rmid_busy", busy, 1'b0);
    reset = 0;
    tick();
    if (if_ack || d_ack) ack_seen++;
    chk("rmid_rearb_m_req", m_req, 1'b1);
    chk("rmid_rearb_m_addr", m_addr, 16'h0777);
    chk("rmid_no_ack", ack_seen, 0);
    m_ready = 1; m_rdata = 16'h7777;
    tick();
    chk("rmid_ack", if_ack, 1'b1);
    if_req = 0; m_ready = 0;
    tick();

    // Randomized traffic
    waitc = 0;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      if (if_ack) if_req = 0;
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = 16'($urandom);
      end
      if (d_ack) d_req = 0;
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
      end
      if (m_req) begin
        if (waitc == 0) m_ready = 1;
        else begin m_ready = 0; waitc--; end
      end else begin
        m_ready = ($urandom_range(0, 7) == 0);
        waitc   = $urandom_range(0, 3);
      end
      m_rdata = 16'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares one single-ported 16-bit unified memory between the instruction-fetch stage (read-only) and the MEM-stage load/store path.
- Fixed priority goes to the data port, with an optional anti-starvation guard for fetch.
- Sits between the pipeline's fetch/MEM stages and the memory macro.
- Converts each requester's hold-until-ack request into a single memory transaction over a ready-based backend handshake.

## Interface

Parameters:
- AW, 16, address width (word address)
- DW, 16, data width
- STARVE_LIMIT, 4, consecutive data grants tolerated while fetch waits (range 1–15)

Ports:
- clk  in  1  clock; all state updates on rising edge. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous active-high reset
- if_req  in  1  fetch read request, held until if_ack
- if_addr  in  AW  fetch address, stable while if_req
- if_rdata  out  DW  fetch read data, valid when if_ack
- if_ack  out  1  one-cycle completion pulse to fetch
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = write, 0 = read; stable while d_req
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_rdata  out  DW  load data, valid when d_ack on a read
- d_ack  out  1  one-cycle completion pulse to data port
- m_req  out  1  memory transaction request, held until m_ready
- m_we  out  1  memory write enable
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data, valid with m_ready
- m_ready  in  1  memory completes the current transaction this cycle
- busy  out  1  state ≠ IDLE

## Operation

- FSM states:
  - IDLE: no grant outstanding.
  - BUSY: transaction on memory.
  - ACK: ack pulse cycle.
- **IDLE**:
  - Arbitrate among requests sampled this cycle; if none, stay IDLE.
  - Winner's address, write data and we are registered onto m_addr/m_wdata/m_we; m_req is set to 1; grant owner is recorded; go to BUSY.
  - Fetch grants always have m_we = 0.
- **Arbitration**: d_req wins over if_req (subject to the guard in Configuration).
- **BUSY**:
  - m_req and m_* outputs are held constant.
  - On m_ready: capture m_rdata into the owner's rdata register (reads only), drop m_req, go to ACK.
- **ACK**:
  - Owner's ack = 1 for exactly this cycle; then go to IDLE.
  - The requester deasserts or changes req at this same edge; IDLE arbitrates fresh values.
- Data writes leave d_rdata unchanged. if_rdata and d_rdata hold their last captured value otherwise.
- A requester dropping req while in BUSY is illegal; the transaction completes regardless.

## Timing

- **Reset values** (any state, mid-transaction included):
  - state = IDLE
  - m_req = 0, m_we = 0, m_addr = 0, m_wdata = 0
  - if_ack = 0, d_ack = 0
  - if_rdata = 0, d_rdata = 0
  - busy = 0
  - starve counter = 0
- A transaction aborted by reset is dropped with no ack.
- **Request to ack**:
  - req high at cycle 0 (IDLE) → m_req high cycle 1.
  - m_ready at cycle k ≥ 1 → ack high cycle k+1 → IDLE cycle k+2.
- Minimum 3 cycles per transfer (m_ready in the first BUSY cycle). Back-to-back transfers give no more than one memory transaction per 3 cycles.
- m_ready outside BUSY is ignored.
- if_ack and d_ack are never high together.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration

- **MEMARB_STARVE_GUARD_EN defined**:
  - A 4-bit starve counter increments on each data grant made while if_req is also high.
  - When counter == STARVE_LIMIT and both requests are pending, fetch is granted and the counter is cleared.
  - Counter is also cleared on any fetch grant, and on any data grant made with if_req low.
- **Undefined**: strict data-over-fetch priority. No counter logic.

## Test plan

- **Single fetch**: if_req=1, if_addr=0x0010, m_ready=1 one cycle after m_req, m_rdata=0xA5C3 → m_req cycle 1 with m_addr=0x0010, m_we=0; if_ack cycle 3 with if_rdata=0xA5C3.
- **Simultaneous**: if_req and d_req (write, d_addr=0x0200, d_wdata=0x1234) both at cycle 0 → first m_req has m_we=1, m_addr=0x0200, m_wdata=0x1234; d_ack first, d_rdata unchanged; fetch granted at the next IDLE.
- **Memory wait states**: m_ready delayed 5 cycles → m_req and m_addr constant throughout; ack exactly one cycle after m_ready; busy high for 6 cycles.
- **Starvation, STARVE_LIMIT=4, macro defined**: d_req held continuously with if_req pending → 4 data grants, then 1 fetch grant, then data resumes. Without the macro, fetch is never granted while d_req is held.
- **Reset mid-transaction**: reset asserted during BUSY → next cycle m_req=0, busy=0, no ack ever for that request; after reset release, a held if_req is re-arbitrated normally.
